// File: rtl/stream_pattern_counter.sv
// stream_pattern_counter: counts overlapping pattern matches across the words of a framed serial bit stream
// Ports: clk, rst (async, active-high), clear (sync abort of frame and held result)
//        pattern            - pattern to match, sampled on the first beat of each frame
//        pattern_mask       - per-bit care mask, present only when STREAM_PATTERN_MASK_EN is defined
//        in_data/in_valid/in_last/in_ready      - input words, bit DATA_WIDTH-1 first in time
//        count_out/overflow/count_valid/count_ready - saturating per-frame match total
module stream_pattern_counter #(
    parameter int DATA_WIDTH     = 32,
    parameter int PATTERN_WIDTH  = 3,
    parameter int COUNT_WIDTH    = 16,
    parameter int WORD_CNT_WIDTH = $clog2(DATA_WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [PATTERN_WIDTH-1:0] pattern,
`ifdef STREAM_PATTERN_MASK_EN
    input  logic [PATTERN_WIDTH-1:0] pattern_mask,
`endif
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [COUNT_WIDTH-1:0]   count_out,
    output logic                     overflow,
    output logic                     count_valid,
    input  logic                     count_ready
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, state_next;
    logic [PATTERN_WIDTH-2:0] carry;
    logic carry_valid;
    logic [PATTERN_WIDTH-1:0] pat_reg, pat_eff, mask_eff;
    logic [DATA_WIDTH+PATTERN_WIDTH-2:0] ext;
    logic [WORD_CNT_WIDTH-1:0] word_cnt;
    logic [COUNT_WIDTH:0] sum;
    logic beat, first;
    assign count_valid = state == DONE;
    assign in_ready = !count_valid;
    assign beat = in_valid && in_ready;
    assign first = state == IDLE;
    assign pat_eff = first ? pattern : pat_reg;
    assign ext = {carry, in_data};
    // count_out doubles as the accumulator; a new frame restarts from zero
    assign sum = (COUNT_WIDTH+1)'(first ? '0 : count_out) + (COUNT_WIDTH+1)'(word_cnt);
`ifdef STREAM_PATTERN_MASK_EN
    logic [PATTERN_WIDTH-1:0] mask_reg;
    assign mask_eff = first ? pattern_mask : mask_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mask_reg <= '0;
        else if (!clear && beat && first)
            mask_reg <= pattern_mask;
    end
`else
    assign mask_eff = '1;
`endif
    // windows above DATA_WIDTH-PATTERN_WIDTH reach into the previous word's carry bits
    always_comb begin
        word_cnt = '0;
        for (int j = 0; j < DATA_WIDTH; j++)
            if ((j <= DATA_WIDTH - PATTERN_WIDTH || carry_valid) &&
                (((ext[j+PATTERN_WIDTH-1 -: PATTERN_WIDTH] ^ pat_eff) & mask_eff) == '0))
                word_cnt = word_cnt + WORD_CNT_WIDTH'(1);
    end
    always_comb begin
        state_next = state;
        if (clear)
            state_next = IDLE;
        else if (state == DONE)
            state_next = count_ready ? IDLE : DONE;
        else if (beat)
            state_next = in_last ? DONE : ACCUM;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out   <= '0;
            overflow    <= 1'b0;
            carry       <= '0;
            carry_valid <= 1'b0;
            pat_reg     <= '0;
        end else if (clear) begin
            count_out   <= '0;
            overflow    <= 1'b0;
            carry_valid <= 1'b0;
        end else if (beat) begin
            count_out   <= sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
            overflow    <= (overflow && !first) || sum[COUNT_WIDTH];
            carry       <= in_data[PATTERN_WIDTH-2:0];
            carry_valid <= !in_last;
            if (first)
                pat_reg <= pattern;
        end
    end
endmodule

// File: tb/tb_stream_pattern_counter.sv
// tb_stream_pattern_counter: randomized and directed checks of stream_pattern_counter against a bit-queue model
module tb_stream_pattern_counter;
    localparam int DW = 8;
    localparam int PW = 3;
    localparam int CW = 4;
`ifdef STREAM_PATTERN_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif
    typedef logic [DW-1:0] word_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic count_ready = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, overflow, count_valid;
    logic [CW-1:0] count_out;
`ifdef STREAM_PATTERN_MASK_EN
    logic [PW-1:0] pattern_mask = '1;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_pattern_counter #(.DATA_WIDTH(DW), .PATTERN_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .pattern(pattern),
`ifdef STREAM_PATTERN_MASK_EN
        .pattern_mask(pattern_mask),
`endif
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .count_out(count_out),
        .overflow(overflow),
        .count_valid(count_valid),
        .count_ready(count_ready)
    );

    // Reference: flatten the frame into one bit stream and slide the pattern over every position.
    function automatic void model(input word_q_t w, input logic [PW-1:0] pat, input logic [PW-1:0] msk,
                                  output logic [CW-1:0] cnt, output logic ovf);
        bit bits[$];
        int total;
        bit hit;
        total = 0;
        foreach (w[i])
            for (int b = DW - 1; b >= 0; b--)
                bits.push_back(w[i][b]);
        for (int i = 0; i + PW <= bits.size(); i++) begin
            hit = 1'b1;
            for (int k = 0; k < PW; k++)
                if (msk[PW-1-k] && bits[i+k] != pat[PW-1-k])
                    hit = 1'b0;
            if (hit)
                total++;
        end
        ovf = total >= (1 << CW);
        cnt = ovf ? '1 : CW'(total);
    endfunction

    task automatic send_word(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_word_timeout in_ready=%b required 1", in_ready);
        end
        in_data = d;
        in_last = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic play_frame(input word_q_t w, input logic [PW-1:0] pat, input bit scramble,
                              output logic [CW-1:0] cnt, output logic ovf, output bit got);
        int n;
        pattern = pat;
        foreach (w[i]) begin
            send_word(w[i], i == w.size() - 1);
            if (scramble) begin
                pattern = PW'($urandom);
`ifdef STREAM_PATTERN_MASK_EN
                pattern_mask = PW'($urandom);
`endif
            end
        end
        n = 0;
        @(negedge clk);
        while (!count_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        got = count_valid;
        cnt = count_out;
        ovf = overflow;
        if (scramble)
            repeat ($urandom_range(0, 2)) @(negedge clk);
        count_ready = 1'b1;
        @(posedge clk);
        #1;
        count_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        checks++;
        if (count_out !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_count count=%0d ovf=%b required 0/0", count_out, overflow);
        end
        checks++;
        if (count_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake valid=%b ready=%b required 0/1", count_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_boundary_example;
        pattern = 3'b101;
        send_word(8'hAA, 1'b0);
        checks++;
        if (count_valid !== 1'b0) begin
            errors++;
            $display("FAIL example_midframe_valid got=%b required 0", count_valid);
        end
        send_word(8'h80, 1'b1);
        checks++;
        if (count_valid !== 1'b1) begin
            errors++;
            $display("FAIL example_latency valid=%b required 1", count_valid);
        end
        checks++;
        if (count_out !== 4'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL example_count count=%0d ovf=%b required 4/0", count_out, overflow);
        end
        count_ready = 1'b1;
        @(posedge clk);
        #1;
        count_ready = 1'b0;
    endtask

    task automatic test_single_word_frames;
        word_q_t w;
        logic [CW-1:0] cnt;
        logic ovf;
        bit got;
        w = {8'h05};
        play_frame(w, 3'b101, 1'b0, cnt, ovf, got);
        checks++;
        if (!got || cnt !== 4'd1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_05 got=%b count=%0d ovf=%b required 1/1/0", got, cnt, ovf);
        end
        w = {8'hA0};
        play_frame(w, 3'b101, 1'b0, cnt, ovf, got);
        checks++;
        if (!got || cnt !== 4'd1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_A0 got=%b count=%0d ovf=%b required 1/1/0", got, cnt, ovf);
        end
    endtask

    task automatic test_saturation;
        word_q_t w;
        logic [CW-1:0] cnt;
        logic ovf;
        bit got;
        w = {8'hFF, 8'hFF, 8'hFF};
        play_frame(w, 3'b111, 1'b0, cnt, ovf, got);
        checks++;
        if (!got || cnt !== 4'd15 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL saturation got=%b count=%0d ovf=%b required 1/15/1", got, cnt, ovf);
        end
    endtask

    task automatic test_back_to_back;
        pattern = 3'b101;
        send_word(8'hAA, 1'b1);
        in_data = 8'hFF;
        in_last = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || count_valid !== 1'b1 || count_out !== 4'd3) begin
                errors++;
                $display("FAIL backpressure_hold cycle=%0d ready=%b valid=%b count=%0d required 0/1/3", c, in_ready, count_valid, count_out);
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        count_ready = 1'b1;
        @(posedge clk);
        #1;
        count_ready = 1'b0;
        checks++;
        if (count_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release valid=%b ready=%b required 0/1", count_valid, in_ready);
        end
    endtask

    task automatic test_pattern_change;
        pattern = 3'b101;
        send_word(8'hAA, 1'b0);
        pattern = 3'b000;
        send_word(8'h00, 1'b1);
        checks++;
        if (count_valid !== 1'b1 || count_out !== 4'd3) begin
            errors++;
            $display("FAIL pattern_change valid=%b count=%0d required 1/3", count_valid, count_out);
        end
        count_ready = 1'b1;
        @(posedge clk);
        #1;
        count_ready = 1'b0;
    endtask

    task automatic test_clear;
        word_q_t w;
        logic [CW-1:0] cnt;
        logic ovf;
        bit got;
        pattern = 3'b101;
        send_word(8'hAA, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        in_data = 8'hFF;
        in_last = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (count_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_drops_beat valid=%b ready=%b required 0/1", count_valid, in_ready);
        end
        w = {8'h80};
        play_frame(w, 3'b101, 1'b0, cnt, ovf, got);
        checks++;
        if (!got || cnt !== 4'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL clear_fresh_frame got=%b count=%0d ovf=%b required 1/0/0", got, cnt, ovf);
        end
        send_word(8'hAA, 1'b1);
        @(negedge clk);
        clear = 1'b1;
        count_ready = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        count_ready = 1'b0;
        checks++;
        if (count_valid !== 1'b0 || count_out !== '0) begin
            errors++;
            $display("FAIL clear_held_result valid=%b count=%0d required 0/0", count_valid, count_out);
        end
    endtask

    task automatic test_async_reset;
        word_q_t w;
        logic [CW-1:0] cnt;
        logic ovf;
        bit got;
        pattern = 3'b111;
        send_word(8'hFF, 1'b0);
        send_word(8'hFF, 1'b0);
        send_word(8'hFF, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (count_out !== '0 || overflow !== 1'b0 || count_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset count=%0d ovf=%b valid=%b ready=%b required 0/0/0/1", count_out, overflow, count_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        pattern = 3'b101;
        send_word(8'hAA, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        w = {8'h80};
        play_frame(w, 3'b101, 1'b0, cnt, ovf, got);
        checks++;
        if (!got || cnt !== 4'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_midframe got=%b count=%0d ovf=%b required 1/0/0", got, cnt, ovf);
        end
    endtask

`ifdef STREAM_PATTERN_MASK_EN
    task automatic test_mask;
        word_q_t w;
        logic [CW-1:0] cnt;
        logic ovf;
        bit got;
        pattern_mask = 3'b100;
        w = {8'hF0};
        play_frame(w, 3'b100, 1'b0, cnt, ovf, got);
        checks++;
        if (!got || cnt !== 4'd4) begin
            errors++;
            $display("FAIL mask_msb got=%b count=%0d required 1/4", got, cnt);
        end
        pattern_mask = 3'b000;
        w = {DW'($urandom)};
        play_frame(w, PW'($urandom), 1'b0, cnt, ovf, got);
        checks++;
        if (!got || cnt !== 4'd6) begin
            errors++;
            $display("FAIL mask_zero got=%b count=%0d required 1/6", got, cnt);
        end
        pattern_mask = '1;
    endtask
`endif

    task automatic test_random;
        for (int f = 0; f < 60; f++) begin
            word_q_t w;
            logic [PW-1:0] pat, msk;
            logic [CW-1:0] cnt, exp_cnt;
            logic ovf, exp_ovf;
            bit got;
            int len;
            w = {};
            len = $urandom_range(1, 4);
            pat = ($urandom_range(0, 3) == 0) ? 3'b111 : PW'($urandom);
            msk = ($urandom_range(0, 2) == 0) ? PW'($urandom) : '1;
            for (int i = 0; i < len; i++)
                w.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : DW'($urandom));
`ifdef STREAM_PATTERN_MASK_EN
            pattern_mask = msk;
`endif
            model(w, pat, MASK_EN ? msk : '1, exp_cnt, exp_ovf);
            play_frame(w, pat, 1'b1, cnt, ovf, got);
            checks++;
            if (!got || cnt !== exp_cnt) begin
                errors++;
                $display("FAIL random_count frame=%0d got=%b count=%0d required %0d", f, got, cnt, exp_cnt);
            end
            checks++;
            if (ovf !== exp_ovf) begin
                errors++;
                $display("FAIL random_overflow frame=%0d ovf=%b required %b", f, ovf, exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset;
        test_boundary_example;
        test_single_word_frames;
        test_saturation;
        test_back_to_back;
        test_pattern_change;
        test_clear;
        test_async_reset;
`ifdef STREAM_PATTERN_MASK_EN
        test_mask;
`endif
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
